// File: rtl/mm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_pkg : sequencer state encoding, default matrix size, FP32 constants
// Rev 1.0
// ----------------------------------------------------------------------------
package mm_pkg;

    localparam int c_LOG2_DIM_DEFAULT = 2;

    typedef logic [2:0] mm_state_t;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CLEAR  = 3'd1;
    localparam logic [2:0] c_STREAM = 3'd2;
    localparam logic [2:0] c_DRAIN  = 3'd3;
    localparam logic [2:0] c_WRITE  = 3'd4;
    localparam logic [2:0] c_FINISH = 3'd5;

    localparam logic [31:0] c_FP32_ONE   = 32'h3F80_0000;
    localparam logic [31:0] c_FP32_TWO   = 32'h4000_0000;
    localparam logic [31:0] c_FP32_EIGHT = 32'h4100_0000;

endpackage
`default_nettype wire

// File: rtl/mm_index_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_index_counter : i/j/k loop counters with last flags and RAM addresses
// Rev 1.0
// ----------------------------------------------------------------------------
module mm_index_counter #(
    parameter int LOG2_DIM = 2
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    i_clr_all,
    input  logic                    i_k_clr,
    input  logic                    i_k_inc,
    input  logic                    i_j_inc,
    output logic                    o_k_last,
    output logic                    o_ij_last,
    output logic [2*LOG2_DIM-1:0]   o_a_addr,
    output logic [2*LOG2_DIM-1:0]   o_b_addr,
    output logic [2*LOG2_DIM-1:0]   o_c_addr
);

    localparam logic [LOG2_DIM-1:0] c_IDX_MAX = '1;

    logic [LOG2_DIM-1:0] r_i;
    logic [LOG2_DIM-1:0] r_j;
    logic [LOG2_DIM-1:0] r_k;

    always_ff @(posedge clk) begin
        if (!clr_n || i_clr_all) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else begin
            if (i_k_clr) begin
                r_k <= '0;
            end else if (i_k_inc) begin
                r_k <= r_k + 1'b1;
            end
            // j wraps naturally at DIM; the row advances on that wrap
            if (i_j_inc) begin
                r_j <= r_j + 1'b1;
                if (r_j == c_IDX_MAX) begin
                    r_i <= r_i + 1'b1;
                end
            end
        end
    end

    assign o_k_last  = (r_k == c_IDX_MAX);
    assign o_ij_last = (r_i == c_IDX_MAX) && (r_j == c_IDX_MAX);

    // Row-major addresses: concatenation equals row*DIM+col for DIM = 2**LOG2_DIM
    assign o_a_addr = {r_i, r_k};
    assign o_b_addr = {r_k, r_j};
    assign o_c_addr = {r_i, r_j};

endmodule
`default_nettype wire

// File: rtl/mm_pe_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_pe_sequencer : drives one MAC PE through C = A x B, one C element at a time
// Optional DRAIN timeout/abort enabled by macro PE_TIMEOUT_EN.   Rev 1.0
// ----------------------------------------------------------------------------
module mm_pe_sequencer
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_DIM   = c_LOG2_DIM_DEFAULT,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    cmd_start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    a_rd_en,
    output logic [2*LOG2_DIM-1:0]   a_rd_addr,
    input  logic [DATA_WIDTH-1:0]   a_rd_data,
    output logic                    b_rd_en,
    output logic [2*LOG2_DIM-1:0]   b_rd_addr,
    input  logic [DATA_WIDTH-1:0]   b_rd_data,
    output logic                    pe_start,
    output logic                    pe_valid,
    output logic                    pe_last,
    output logic [DATA_WIDTH-1:0]   pe_a,
    output logic [DATA_WIDTH-1:0]   pe_b,
    input  logic [DATA_WIDTH-1:0]   pe_c,
    input  logic                    pe_out_valid,
    output logic                    c_wr_en,
    output logic [2*LOG2_DIM-1:0]   c_wr_addr,
    output logic [DATA_WIDTH-1:0]   c_wr_data
);

    mm_state_t              r_state;
    logic                   r_pe_valid;
    logic                   r_pe_last;
    logic [DATA_WIDTH-1:0]  r_c_wr_data;

    logic w_in_idle;
    logic w_in_clear;
    logic w_in_stream;
    logic w_in_drain;
    logic w_in_write;
    logic w_in_finish;
    logic w_start_acc;
    logic w_k_last;
    logic w_ij_last;
    logic w_timeout;

    assign w_in_idle   = (r_state == c_IDLE);
    assign w_in_clear  = (r_state == c_CLEAR);
    assign w_in_stream = (r_state == c_STREAM);
    assign w_in_drain  = (r_state == c_DRAIN);
    assign w_in_write  = (r_state == c_WRITE);
    assign w_in_finish = (r_state == c_FINISH);
    assign w_start_acc = w_in_idle && cmd_start;

    mm_index_counter #(
        .LOG2_DIM (LOG2_DIM)
    ) u_idx (
        .clk       (clk),
        .clr_n     (clr_n),
        .i_clr_all (w_start_acc),
        .i_k_clr   (w_in_clear),
        .i_k_inc   (w_in_stream),
        .i_j_inc   (w_in_write && !w_ij_last),
        .o_k_last  (w_k_last),
        .o_ij_last (w_ij_last),
        .o_a_addr  (a_rd_addr),
        .o_b_addr  (b_rd_addr),
        .o_c_addr  (c_wr_addr)
    );

`ifdef PE_TIMEOUT_EN
    localparam int            c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic               r_err;
    logic [c_TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_err     <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
            r_tmo_cnt <= w_in_drain ? r_tmo_cnt + 1'b1 : '0;
        end
    end

    assign w_timeout = w_in_drain && !pe_out_valid && (r_tmo_cnt == c_TMO_LAST);
    assign err       = r_err;
`else
    localparam int c_unused_timeout = TIMEOUT;

    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state     <= c_IDLE;
            r_pe_valid  <= 1'b0;
            r_pe_last   <= 1'b0;
            r_c_wr_data <= '0;
        end else begin
            // RAM read latency is one cycle, so framing trails the read strobe by one
            r_pe_valid <= w_in_stream;
            r_pe_last  <= w_in_stream && w_k_last;
            case (r_state)
                c_IDLE:   if (cmd_start) r_state <= c_CLEAR;
                c_CLEAR:  r_state <= c_STREAM;
                c_STREAM: if (w_k_last) r_state <= c_DRAIN;
                c_DRAIN: begin
                    if (pe_out_valid) begin
                        r_c_wr_data <= pe_c;
                        r_state     <= c_WRITE;
                    end else if (w_timeout) begin
                        r_state <= c_IDLE;
                    end
                end
                c_WRITE:  r_state <= w_ij_last ? c_FINISH : c_CLEAR;
                c_FINISH: r_state <= c_IDLE;
                default:  r_state <= c_IDLE;
            endcase
        end
    end

    assign busy      = !w_in_idle && !w_in_finish;
    assign done      = w_in_finish;
    assign a_rd_en   = w_in_stream;
    assign b_rd_en   = w_in_stream;
    assign pe_start  = w_in_clear;
    assign pe_valid  = r_pe_valid;
    assign pe_last   = r_pe_last;
    assign pe_a      = a_rd_data;
    assign pe_b      = b_rd_data;
    assign c_wr_en   = w_in_write;
    assign c_wr_data = r_c_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mm_pe_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mm_pe_sequencer : RAM + FP32 MAC PE models around the sequencer, vector table
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mm_pe_sequencer;
    import mm_pkg::*;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        busy, done, err;
    logic        a_rd_en, b_rd_en;
    logic [3:0]  a_rd_addr, b_rd_addr, c_wr_addr;
    logic [31:0] a_rd_data, b_rd_data;
    logic        pe_start, pe_valid, pe_last, pe_out_valid;
    logic [31:0] pe_a, pe_b, pe_c;
    logic        c_wr_en;
    logic [31:0] c_wr_data;

    always #5 clk = ~clk;

    mm_pe_sequencer #(
        .DATA_WIDTH (32),
        .LOG2_DIM   (2),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .cmd_start    (cmd_start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .a_rd_en      (a_rd_en),
        .a_rd_addr    (a_rd_addr),
        .a_rd_data    (a_rd_data),
        .b_rd_en      (b_rd_en),
        .b_rd_addr    (b_rd_addr),
        .b_rd_data    (b_rd_data),
        .pe_start     (pe_start),
        .pe_valid     (pe_valid),
        .pe_last      (pe_last),
        .pe_a         (pe_a),
        .pe_b         (pe_b),
        .pe_c         (pe_c),
        .pe_out_valid (pe_out_valid),
        .c_wr_en      (c_wr_en),
        .c_wr_addr    (c_wr_addr),
        .c_wr_data    (c_wr_data)
    );

    // ---------------- FP32 helpers (exact for the small values used here)
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        m = 1.0 + $itor(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic        s;
        int          e;
        real         m;
        logic [22:0] mant;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        mant = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, 8'(e), mant};
    endfunction

    // ---------------- RAM models (1-cycle read latency)
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
        if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
    end

    // ---------------- PE model: result 3 cycles after the last beat
    logic        pe_stub = 1'b0;
    real         acc = 0.0;
    logic        pv1 = 1'b0, pv2 = 1'b0, pv3 = 1'b0;
    logic [31:0] pr1 = '0, pr2 = '0, pr3 = '0;

    always @(posedge clk) begin
        pv1 <= 1'b0;
        if (pe_start) begin
            acc <= 0.0;
        end else if (pe_valid) begin
            acc <= acc + f2r(pe_a) * f2r(pe_b);
            if (pe_last) begin
                pv1 <= 1'b1;
                pr1 <= r2f(acc + f2r(pe_a) * f2r(pe_b));
            end
        end
        pv2 <= pv1; pr2 <= pr1;
        pv3 <= pv2; pr3 <= pr2;
    end

    assign pe_out_valid = pv3 && !pe_stub;
    assign pe_c         = pr3;

    // ---------------- Monitor: records writes, reads, framing per run
    int          run_id = 0;
    int          seen_id = 0;
    logic [3:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] frame_q [$];
    logic [8:0]  rd_q [$];
    int          done_cnt = 0;
    int          n_start = 0, n_valid = 0, n_last = 0, n_bad = 0;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (seen_id != run_id) begin
            seen_id = run_id;
            wr_addr_q.delete(); wr_data_q.delete(); frame_q.delete(); rd_q.delete();
            done_cnt = 0; n_start = 0; n_valid = 0; n_last = 0; n_bad = 0;
            prev_valid = 1'b0;
        end
        if (done) done_cnt++;
        if (a_rd_en || b_rd_en) rd_q.push_back({a_rd_en == b_rd_en, a_rd_addr, b_rd_addr});
        if (pe_start) n_start++;
        if (pe_last && !(pe_valid && n_valid == 3)) n_bad++;
        if (pe_valid && !prev_valid && n_valid != 0) n_bad++;
        if (pe_valid) n_valid++;
        if (pe_last) n_last++;
        prev_valid = pe_valid;
        if (c_wr_en) begin
            wr_addr_q.push_back(c_wr_addr);
            wr_data_q.push_back(c_wr_data);
            frame_q.push_back({8'(n_start), 8'(n_valid), 8'(n_last), 8'(n_bad)});
            n_start = 0; n_valid = 0; n_last = 0; n_bad = 0;
        end
    end

    // ---------------- Checking
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_now();
        return 64'({busy, done, err, a_rd_en, b_rd_en, pe_start, pe_valid, pe_last,
                    c_wr_en, a_rd_addr, b_rd_addr, c_wr_addr, c_wr_data});
    endfunction

    typedef struct {
        int                a_sel;
        int                b_sel;
        logic [15:0][31:0] exp_c;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] flt [16];

    function automatic logic [31:0] pat(input int sel, input int r, input int c);
        case (sel)
            0:       return c_FP32_ONE;
            1:       return c_FP32_TWO;
            2:       return (r == c) ? c_FP32_ONE : 32'h0;
            3:       return flt[r*4 + c];
            4:       return (r == c) ? c_FP32_TWO : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic load(input int a_sel, input int b_sel);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                mem_a[r*4 + c] = pat(a_sel, r, c);
                mem_b[r*4 + c] = pat(b_sel, r, c);
            end
        end
    endtask

    task automatic run_mm(input string tag, input int mode);
        bit seen = 1'b0;
        bit inj  = 1'b0;
        run_id++;
        @(posedge clk); #1 cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
        chk({tag, " err_after_start"}, 64'(err), 64'd0);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (mode == 1 && !inj && wr_addr_q.size() == 3 && a_rd_en) begin
                cmd_start = 1'b1;
                inj = 1'b1;
            end else if (cmd_start) begin
                cmd_start = 1'b0;
            end
            if (done) begin seen = 1'b1; break; end
        end
        cmd_start = 1'b0;
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        if (mode == 1) chk({tag, " start_injected"}, 64'(inj), 64'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input logic [15:0][31:0] exp_c);
        int i, j, k, e;
        chk({tag, " wr_count"}, 64'(wr_addr_q.size()), 64'd16);
        for (int n = 0; n < 16 && n < wr_addr_q.size(); n++) begin
            chk($sformatf("%s wr_addr[%0d]", tag, n), 64'(wr_addr_q[n]), 64'(n));
            chk($sformatf("%s wr_data[%0d]", tag, n), 64'(wr_data_q[n]), 64'(exp_c[n]));
        end
        chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, " busy_idle"}, 64'(busy), 64'd0);
        chk({tag, " err_idle"}, 64'(err), 64'd0);
        chk({tag, " frame_count"}, 64'(frame_q.size()), 64'd16);
        for (int n = 0; n < frame_q.size(); n++)
            chk($sformatf("%s framing[%0d]", tag, n), 64'(frame_q[n]), 64'h01040100);
        chk({tag, " read_count"}, 64'(rd_q.size()), 64'd64);
        for (int n = 0; n < rd_q.size(); n++) begin
            e = n / 4; k = n % 4; i = e / 4; j = e % 4;
            chk($sformatf("%s rd[%0d]", tag, n), 64'(rd_q[n]),
                64'({1'b1, 4'(i*4 + k), 4'(k*4 + j)}));
        end
    endtask

    initial begin
        int  n;
        bit  hit;

        flt = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
                32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
                32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};

        vecs[0].a_sel = 0; vecs[0].b_sel = 1;
        vecs[1].a_sel = 2; vecs[1].b_sel = 3;
        vecs[2].a_sel = 4; vecs[2].b_sel = 0;
        vecs[3].a_sel = 3; vecs[3].b_sel = 2;
        for (int e = 0; e < 16; e++) begin
            vecs[0].exp_c[e] = c_FP32_EIGHT;
            vecs[1].exp_c[e] = flt[e];
            vecs[2].exp_c[e] = c_FP32_TWO;
            vecs[3].exp_c[e] = flt[e];
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs_now(), 64'd0);
        @(posedge clk); #1 clr_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", outs_now(), 64'd0);

        // Vector table
        for (int v = 0; v < 4; v++) begin
            load(vecs[v].a_sel, vecs[v].b_sel);
            run_mm($sformatf("vec%0d", v), 0);
            check_result($sformatf("vec%0d", v), vecs[v].exp_c);
        end

        // cmd_start during STREAM of element 3 is ignored
        load(0, 1);
        run_mm("inject", 1);
        check_result("inject", vecs[0].exp_c);

        // Reset during DRAIN of element 5
        run_id++;
        @(posedge clk); #1 cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        hit = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (wr_addr_q.size() == 5 && pe_last) begin hit = 1'b1; break; end
        end
        chk("abort_reached_drain", 64'(hit), 64'd1);
        @(posedge clk); #1 clr_n = 1'b0;
        @(posedge clk); #1 clr_n = 1'b1;
        @(negedge clk);
        chk("abort_outputs_zero", outs_now(), 64'd0);
        repeat (30) @(negedge clk);
        chk("abort_wr_count", 64'(wr_addr_q.size()), 64'd5);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        run_mm("after_abort", 0);
        check_result("after_abort", vecs[0].exp_c);

`ifdef PE_TIMEOUT_EN
        // PE never answers: timeout after TMO DRAIN cycles
        pe_stub = 1'b1;
        run_id++;
        @(posedge clk); #1 cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        hit = 1'b0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (a_rd_en) begin hit = 1'b1; break; end
        end
        for (n = 0; n < 50 && a_rd_en; n++) @(negedge clk);
        chk("tmo_stream_seen", 64'(hit), 64'd1);
        n = 0;
        while (!err && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_drain_cycles", 64'(n), 64'(TMO));
        chk("tmo_err", 64'(err), 64'd1);
        chk("tmo_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("tmo_no_writes", 64'(wr_addr_q.size()), 64'd0);
        chk("tmo_no_done", 64'(done_cnt), 64'd0);
        chk("tmo_err_sticky", 64'(err), 64'd1);
        pe_stub = 1'b0;
        run_mm("after_tmo", 0);
        check_result("after_tmo", vecs[0].exp_c);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
